// File: rtl/mmio_data_mem.sv
// mmio_data_mem: data RAM plus memory-mapped peripherals for the single-cycle MIPS core.
//
// Address map:
//   RAM      addr[30]=0, addr[31:RAM_AW+2]=0, word index addr[RAM_AW+1:2]
//   timer n  0x4000_0000 + 0x10*n : +0 TH, +4 TL, +8 TCON{status,ie,en}, +C PSC
//   LED      0x4000_0100, SWITCH 0x4000_0104 (read-only), DIGI 0x4000_0108
//   Anything else reads 0 and ignores writes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_read        read strobe; rdata is 0 while low
//   mem_write       write strobe, captured on the rising edge
//   addr, wdata     byte address (bits [1:0] ignored) and write data
//   byte_en         RAM byte lane enables (peripherals always take full wdata)
//   switch          switch inputs
//   rdata           combinational read data
//   led, digi       LED and 7-segment registers
//   irq, irq_any    per-timer sticky interrupt status and its OR
module mmio_data_mem #(
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned RAM_AW     = 8,
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned SW_W       = 8,
    parameter int unsigned DIGI_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            byte_en,
    input  logic [SW_W-1:0]       switch,
    output logic [31:0]           rdata,
    output logic [LED_W-1:0]      led,
    output logic [DIGI_W-1:0]     digi,
    output logic [NUM_TIMERS-1:0] irq,
    output logic                  irq_any
);

    localparam logic [23:0] TMR_PAGE = 24'h40_0000;
    localparam logic [29:0] LED_WA   = 30'h1000_0040;
    localparam logic [29:0] SW_WA    = 30'h1000_0041;
    localparam logic [29:0] DIGI_WA  = 30'h1000_0042;

    // Address decode
    logic              ram_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              tmr_page;
    logic              led_sel;
    logic              sw_sel;
    logic              digi_sel;
    logic              unused_addr;

    assign ram_sel     = ~addr[30] && (addr[31:RAM_AW+2] == '0);
    assign ram_idx     = addr[RAM_AW+1:2];
    assign tmr_page    = (addr[31:8] == TMR_PAGE);
    assign led_sel     = (addr[31:2] == LED_WA);
    assign sw_sel      = (addr[31:2] == SW_WA);
    assign digi_sel    = (addr[31:2] == DIGI_WA);
    assign unused_addr = ^addr[1:0];

    // Data RAM, not reset
    logic [31:0] ram [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (mem_write && ram_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Timer state
    logic [31:0]           th  [NUM_TIMERS];
    logic [31:0]           tl  [NUM_TIMERS];
    logic [15:0]           psc [NUM_TIMERS];
    logic [15:0]           pc  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en;
    logic [NUM_TIMERS-1:0] ie;
    logic [NUM_TIMERS-1:0] status;

    logic [NUM_TIMERS-1:0] tmr_sel;
    logic [NUM_TIMERS-1:0] th_we;
    logic [NUM_TIMERS-1:0] tl_we;
    logic [NUM_TIMERS-1:0] tcon_we;
    logic [NUM_TIMERS-1:0] psc_we;
    logic [NUM_TIMERS-1:0] tick;
    logic [NUM_TIMERS-1:0] tl_max;
    logic [NUM_TIMERS-1:0] reload;

    // Per-channel write strobes and tick/reload conditions; a TL write swallows the tick
    always_comb begin
        tmr_sel = '0;
        th_we   = '0;
        tl_we   = '0;
        tcon_we = '0;
        psc_we  = '0;
        tick    = '0;
        tl_max  = '0;
        reload  = '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            tmr_sel[n] = tmr_page && (addr[7:4] == 4'(n));
            th_we[n]   = mem_write && tmr_sel[n] && (addr[3:2] == 2'd0);
            tl_we[n]   = mem_write && tmr_sel[n] && (addr[3:2] == 2'd1);
            tcon_we[n] = mem_write && tmr_sel[n] && (addr[3:2] == 2'd2);
            psc_we[n]  = mem_write && tmr_sel[n] && (addr[3:2] == 2'd3);
            tick[n]    = en[n] && (pc[n] == psc[n]);
            tl_max[n]  = (tl[n] == 32'hFFFF_FFFF);
            reload[n]  = tick[n] && !tl_we[n] && tl_max[n];
        end
    end

    // Timer registers; a status set beats a same-cycle W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                th[n]  <= '0;
                tl[n]  <= '0;
                psc[n] <= '0;
                pc[n]  <= '0;
            end
            en     <= '0;
            ie     <= '0;
            status <= '0;
        end else begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                if (th_we[n]) th[n] <= wdata;

                if (tl_we[n])      tl[n] <= wdata;
                else if (tick[n])  tl[n] <= tl_max[n] ? th[n] : tl[n] + 32'd1;

                if (psc_we[n]) psc[n] <= wdata[15:0];

                if (!en[n] || tick[n]) pc[n] <= '0;
                else                   pc[n] <= pc[n] + 16'd1;

                if (tcon_we[n]) begin
                    en[n] <= wdata[0];
                    ie[n] <= wdata[1];
                end

                if (reload[n] && ie[n])            status[n] <= 1'b1;
                else if (tcon_we[n] && wdata[2])   status[n] <= 1'b0;
            end
        end
    end

    assign irq     = status;
    assign irq_any = |status;

    // LED and 7-segment registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led  <= '0;
            digi <= '0;
        end else if (mem_write) begin
            if (led_sel)  led  <= wdata[LED_W-1:0];
            if (digi_sel) digi <= wdata[DIGI_W-1:0];
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (mem_read) begin
            if (ram_sel)  rdata = ram[ram_idx];
            if (led_sel)  rdata = 32'(led);
            if (sw_sel)   rdata = 32'(switch);
            if (digi_sel) rdata = 32'(digi);
            for (int n = 0; n < NUM_TIMERS; n++) begin
                if (tmr_sel[n]) begin
                    case (addr[3:2])
                        2'd0:    rdata = th[n];
                        2'd1:    rdata = tl[n];
                        2'd2:    rdata = {29'b0, status[n], ie[n], en[n]};
                        default: rdata = {16'b0, psc[n]};
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_data_mem.sv
module tb_mmio_data_mem;

    localparam int NT = 2;

    logic          clk;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    byte_en;
    logic [7:0]    switch;
    logic [31:0]   rdata;
    logic [7:0]    led;
    logic [11:0]   digi;
    logic [NT-1:0] irq;
    logic          irq_any;

    mmio_data_mem #(
        .RAM_DEPTH(256), .RAM_AW(8), .NUM_TIMERS(NT),
        .LED_W(8), .SW_W(8), .DIGI_W(12)
    ) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .byte_en(byte_en), .switch(switch),
        .rdata(rdata), .led(led), .digi(digi), .irq(irq), .irq_any(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural state
    logic [31:0] m_th  [NT];
    logic [31:0] m_tl  [NT];
    logic [15:0] m_psc [NT];
    logic [15:0] m_pc  [NT];
    bit          m_en  [NT];
    bit          m_ie  [NT];
    bit          m_st  [NT];
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic [31:0] mram [256];
    logic [3:0]  mval [256];

    initial for (int i = 0; i < 256; i++) mval[i] = 4'h0;

    function automatic bit is_ram(input logic [31:0] a);
        return (a[31:30] == 2'b00) && (a[29:10] == 20'd0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NT; n++) begin
                m_th[n] = 0; m_tl[n] = 0; m_psc[n] = 0; m_pc[n] = 0;
                m_en[n] = 0; m_ie[n] = 0; m_st[n] = 0;
            end
            m_led = 0;
            m_digi = 0;
        end else begin
            logic [31:0] wa;
            wa = {addr[31:2], 2'b00};
            for (int n = 0; n < NT; n++) begin
                bit hit, tick, tlw;
                hit  = mem_write && (wa[31:8] == 24'h40_0000) && (int'(wa[7:4]) == n);
                tlw  = hit && (wa[3:2] == 2'd1);
                tick = m_en[n] && (m_pc[n] == m_psc[n]);
                if (tick && !tlw && m_tl[n] == 32'hFFFF_FFFF && m_ie[n]) m_st[n] = 1;
                else if (hit && wa[3:2] == 2'd2 && wdata[2]) m_st[n] = 0;
                if (tlw) m_tl[n] = wdata;
                else if (tick) m_tl[n] = (m_tl[n] == 32'hFFFF_FFFF) ? m_th[n] : m_tl[n] + 1;
                m_pc[n] = (m_en[n] && !tick) ? m_pc[n] + 1 : 16'd0;
                if (hit && wa[3:2] == 2'd0) m_th[n] = wdata;
                if (hit && wa[3:2] == 2'd3) m_psc[n] = wdata[15:0];
                if (hit && wa[3:2] == 2'd2) begin m_en[n] = wdata[0]; m_ie[n] = wdata[1]; end
            end
            if (mem_write && wa == 32'h4000_0100) m_led = wdata[7:0];
            if (mem_write && wa == 32'h4000_0108) m_digi = wdata[11:0];
            if (mem_write && is_ram(wa)) begin
                for (int b = 0; b < 4; b++) if (byte_en[b]) begin
                    mram[wa[9:2]][8*b +: 8] = wdata[8*b +: 8];
                    mval[wa[9:2]][b] = 1'b1;
                end
            end
        end
    end

    // Expected read value; returns 0 when the addressed RAM word is not fully defined yet
    function automatic bit m_read(input logic [31:0] a, input logic rd, output logic [31:0] v);
        logic [31:0] wa;
        int n;
        v = 0;
        wa = {a[31:2], 2'b00};
        if (!rd) return 1;
        if (is_ram(wa)) begin
            if (mval[wa[9:2]] != 4'hF) return 0;
            v = mram[wa[9:2]];
        end else if (wa[31:8] == 24'h40_0000 && int'(wa[7:4]) < NT) begin
            n = int'(wa[7:4]);
            case (wa[3:2])
                2'd0: v = m_th[n];
                2'd1: v = m_tl[n];
                2'd2: v = {29'd0, m_st[n], m_ie[n], m_en[n]};
                default: v = {16'd0, m_psc[n]};
            endcase
        end else if (wa == 32'h4000_0100) v = {24'd0, m_led};
        else if (wa == 32'h4000_0104) v = {24'd0, switch};
        else if (wa == 32'h4000_0108) v = {20'd0, m_digi};
        return 1;
    endfunction

    // Every-cycle compare against the model
    always @(negedge clk) begin
        logic [31:0] ev;
        logic [NT-1:0] eirq;
        for (int n = 0; n < NT; n++) eirq[n] = m_st[n];
        chk("irq", 32'(irq), 32'(eirq));
        chk("irq_any", 32'(irq_any), 32'(|eirq));
        chk("led", 32'(led), 32'(m_led));
        chk("digi", 32'(digi), 32'(m_digi));
        if (m_read(addr, mem_read, ev)) chk("rdata", rdata, ev);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byte_en = be; mem_write = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b0; addr = 0; wdata = 0; byte_en = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a; mem_read = 1'b1;
        #1;
        chk(name, rdata, exp);
        mem_read = 1'b0; addr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] TH0 = 32'h4000_0000, TL0 = 32'h4000_0004, TC0 = 32'h4000_0008;
    localparam logic [31:0] TL1 = 32'h4000_0014, TC1 = 32'h4000_0018, PS1 = 32'h4000_001C;

    initial begin
        rst = 1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0; byte_en = 0; switch = 8'h00;
        #2;
        rd(TL0, 32'h0, "reset_tl0");
        rd(TC0, 32'h0, "reset_tcon0");
        chk("reset_irq_any", 32'(irq_any), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // RAM byte enables and out-of-range window
        wr(32'h0000_0010, 32'hAABB_CCDD, 4'hF);
        wr(32'h0000_0010, 32'h1122_3344, 4'h5);
        rd(32'h0000_0010, 32'hAA22_CC44, "ram_byte_en");
        wr(32'h0000_0000, 32'hCAFE_F00D, 4'hF);
        wr(32'h0000_0400, 32'h5555_5555, 4'hF);
        rd(32'h0000_0400, 32'h0, "ram_oor_read");
        rd(32'h0000_0003, 32'hCAFE_F00D, "ram_word0_kept");

        // Reload with psc=0
        wr(TH0, 32'hFFFF_FFFC, 4'h0);
        wr(TL0, 32'hFFFF_FFFE, 4'h0);
        wr(TC0, 32'h3, 4'h0);
        rd(TL0, 32'hFFFF_FFFE, "start_no_tick");
        idle(1);
        rd(TL0, 32'hFFFF_FFFF, "tl0_first_tick");
        idle(1);
        rd(TL0, 32'hFFFF_FFFC, "tl0_reload");
        chk("irq_at_reload", 32'(irq), 32'h1);
        chk("irq_any_at_reload", 32'(irq_any), 32'h1);
        chk("model_tl0_reload", m_tl[0], 32'hFFFF_FFFC);
        idle(1);
        rd(TL0, 32'hFFFF_FFFD, "tl0_after_reload");

        // W1C, then W1C colliding with a reload
        wr(TC0, 32'h7, 4'h0);
        rd(TC0, 32'h3, "w1c_clears");
        chk("irq_after_w1c", 32'(irq), 32'h0);
        idle(1);
        rd(TL0, 32'hFFFF_FFFF, "tl0_pre_collide");
        wr(TC0, 32'h7, 4'h0);
        rd(TC0, 32'h7, "set_beats_clear");
        rd(TL0, 32'hFFFF_FFFC, "tl0_collide_reload");
        wr(TC0, 32'h4, 4'h0);
        rd(TC0, 32'h0, "tcon0_off");
        idle(2);
        rd(TL0, 32'hFFFF_FFFD, "tl0_hold");

        // Prescaler on timer 1, timer 0 idle
        wr(PS1, 32'h2, 4'h0);
        wr(TL1, 32'h0, 4'h0);
        wr(TC1, 32'h1, 4'h0);
        idle(2);
        rd(TL1, 32'h0, "psc_2edges");
        idle(1);
        rd(TL1, 32'h1, "psc_3edges");
        idle(3);
        rd(TL1, 32'h2, "psc_6edges");
        rd(TL0, 32'hFFFF_FFFD, "tl0_independent");

        // Bus write to TL on a tick edge wins
        idle(2);
        wr(TL1, 32'h1234, 4'h0);
        rd(TL1, 32'h1234, "tl_write_wins");
        idle(2);
        rd(TL1, 32'h1234, "tl_wait_tick");
        idle(1);
        rd(TL1, 32'h1235, "tl_next_tick");

        // Misc peripherals and unmapped slots
        wr(32'h4000_0024, 32'hDEAD_BEEF, 4'h0);
        rd(32'h4000_0024, 32'h0, "slot2_unmapped");
        switch = 8'h5A;
        rd(32'h4000_0104, 32'h0000_005A, "switch_read");
        wr(32'h4000_0104, 32'h0000_0011, 4'hF);
        rd(32'h4000_0104, 32'h0000_005A, "switch_ro");
        wr(32'h4000_0100, 32'hFFFF_FFA5, 4'h0);
        rd(32'h4000_0100, 32'h0000_00A5, "led_trunc");
        wr(32'h4000_0108, 32'h1234_5ABC, 4'h0);
        rd(32'h4000_0108, 32'h0000_0ABC, "digi_trunc");
        rd(32'h4000_0200, 32'h0, "unmapped_read");

        // Asynchronous reset mid-count with irq pending
        wr(TL0, 32'hFFFF_FFFF, 4'h0);
        wr(TC0, 32'h3, 4'h0);
        idle(1);
        chk("irq_pre_reset", 32'(irq), 32'h1);
        #2 rst = 1;
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_digi", 32'(digi), 32'h0);
        rd(TL0, 32'h0, "rst_tl0");
        rd(TC1, 32'h0, "rst_tcon1");
        rst = 0;
        idle(5);
        rd(TL0, 32'h0, "post_rst_tl0");
        rd(TL1, 32'h0, "post_rst_tl1");

        // Randomized traffic checked by the negedge compare
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1: a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                2:    a = 32'h0000_0400 + {28'd0, 4'($urandom_range(0, 15))};
                3, 4, 5, 6: a = 32'h4000_0000 | {24'd0, 4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
                7:    a = 32'h4000_0100;
                8:    a = 32'h4000_0104;
                9:    a = 32'h4000_0108;
                10:   a = 32'h8000_0010;
                default: a = 32'h4000_0200;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if (a[31:8] == 24'h40_0000 && a[7:4] < 4'd3) begin
                case (a[3:2])
                    2'd0: if ($urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                    2'd1: if ($urandom_range(0, 2) != 0) wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    2'd2: wdata = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                    default: wdata = 32'($urandom_range(0, 3));
                endcase
            end
            addr = a;
            byte_en = 4'($urandom_range(0, 15));
            mem_read = 1'($urandom_range(0, 1));
            mem_write = ($urandom_range(0, 3) == 0);
            switch = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #1 rst = 1;
                #1 rst = 0;
            end
            @(posedge clk);
            #1;
        end
        mem_write = 0;
        mem_read = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_data_mem.md
# mmio_data_mem

Parametrised data memory and memory-mapped peripheral block for the single-cycle MIPS core. It provides word-addressed data RAM with byte-enable writes, NUM_TIMERS independent reload timers with prescaler and sticky, clearable interrupts, and LED, switch and 7-segment registers. All peripherals share one bus port with combinational read and clocked write. It replaces the fixed single-timer memory/peripheral block, and bus writes are never blocked by running timers.

## Interface
- RAM_DEPTH, 256, number of 32-bit RAM words; must be a power of two.
- RAM_AW, 8, log2(RAM_DEPTH).
- NUM_TIMERS, 2, timer channel count, 1..4.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.
- DIGI_W, 12, 7-segment drive register width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- addr  in  32  byte address; bits [1:0] are ignored.
- wdata  in  32  write data.
- byte_en  in  4  byte lane enables for RAM writes; bit i enables wdata[8i+7:8i].
- switch  in  SW_W  switch inputs, read-only.
- rdata  out  32  read data, combinational.
- led  out  LED_W  LED register.
- digi  out  DIGI_W  7-segment register.
- irq  out  NUM_TIMERS  per-timer interrupt status.
- irq_any  out  1  OR of irq.

## Operation

**Address map** (addr[30] selects the peripheral space):
- RAM: addr[30]=0 and addr[31:RAM_AW+2]==0. Word index is addr[RAM_AW+1:2].
- Timer n at 0x4000_0000 + 0x10·n, n < NUM_TIMERS:
  - +0x0 TH, 32-bit reload value.
  - +0x4 TL, 32-bit counter.
  - +0x8 TCON, bits {status, ie, en}.
  - +0xC PSC, 16-bit prescaler.
- Fixed peripheral registers:
  - 0x4000_0100 LED.
  - 0x4000_0104 SWITCH, read-only.
  - 0x4000_0108 DIGI.
- Any other address is unmapped: reads return 0 and writes are ignored. This includes timer slots n ≥ NUM_TIMERS.

**Bus reads:**
- rdata = 0 whenever mem_read=0.
- Narrow registers are zero-extended: TCON reads {29'b0, status, ie, en}, PSC reads {16'b0, psc}.

**Bus writes:**
- RAM writes update only the enabled byte lanes.
- Peripheral writes ignore byte_en and use full wdata, truncated to register width.
- SWITCH writes are ignored.
- TCON write: en ← wdata[0], ie ← wdata[1]. Writing wdata[2]=1 clears status (write-1-to-clear); writing 0 leaves it unchanged.

**Timer n (independent channels):**
- A prescale counter pc (16-bit) runs while en=1. A tick occurs when pc==psc; pc then wraps to 0, otherwise pc increments.
- With psc=0, a tick occurs every enabled cycle.
- On a tick:
  - If TL==0xFFFF_FFFF: TL ← TH, and status ← 1 if ie=1.
  - Otherwise TL ← TL+1, wrapping modulo 2^32.
- When en=0: pc ← 0, and TL and status hold their values.
- Interrupt outputs: irq[n] = status, irq_any = |irq.

**Priority and simultaneous events:**
- A bus write to TL on a tick cycle wins; the tick is lost. pc still advances.
- A write to TH on the reload cycle: the reload uses the old TH.
- A status set and a W1C clear in the same cycle: set wins.
- A write to PSC takes effect on the next comparison. pc is not reset, so if pc > new psc, pc runs up to 0xFFFF and wraps.

**Reset:**
- Cleared to 0: TH, TL, TCON, PSC, pc, led, digi. Consequently irq=0 and irq_any=0.
- RAM contents are not reset and are undefined until written.
- Reset asserted mid-count returns every timer to idle immediately.

## Timing
- Read latency is zero: rdata is combinational from addr, mem_read and the current register/RAM state.
- Write latency is one edge: data is visible on rdata immediately after the capturing rising edge.
- Timer start: the edge that writes en=1 performs no tick. The first tick occurs at the next edge (psc=0) or psc+1 edges later.
- Interrupt: irq[n] rises at the same edge where TL reloads. It falls at the edge of the W1C write, or on rst.
- Period: overflow occurs every (2^32 − TH)·(psc+1) cycles after the first reload.

## Test plan
- Byte-enable RAM write: write 0xAABBCCDD to 0x0000_0010 with byte_en=F, then write 0x11223344 with byte_en=5 → read returns 0xAA22CC44. Reading 0x0000_0400 (out of range, RAM_AW=8) → 0. A write there leaves word 0 unchanged.
- Timer reload, psc=0: timer 0 TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 → TL reads FFFF_FFFF, then FFFF_FFFC on the second edge after enable, with irq[0]=1 and irq_any=1 at that edge. TL continues FFFF_FFFD…
- W1C and collision: write TCON=0x7 while status=1 → status clears, en and ie stay 1. Arrange a reload on the same edge as the W1C write → status remains 1.
- Prescaler and channel independence: timer 1 PSC=2, TL=0, en=1 with timer 0 disabled → timer 1 TL increments every 3 cycles (1 after 3 edges, 2 after 6). Timer 0 TL is unchanged.
- Bus vs. tick priority: write TL=0x1234 on a tick cycle of an enabled timer → TL reads 0x1234, then 0x1235 at the next tick.
- Reset mid-count: assert rst asynchronously between edges while timers run and irq=1 → irq, TL, TCON, led and digi read 0 immediately. After release, timers do not count until en is rewritten.
